pi_code_ctrl: RTL
=================

// Module: pi_code_ctrl
// PURPOSE
// - Sequences the 11-bit phase-interpolator code (PMIX Code[10:0]) from bang-bang phase-detector votes.
// - Code layout: [10:8] octant select, [7:0] mixing weight.
// - Integrates early/late votes and steps the code by a state-dependent amount.
// - Two-speed loop: coarse ACQUIRE, then fine TRACK after lock. Also provides freeze and direct load.
// - Sits between the CDR phase detector/voter and the PI, inside the RX CDR.
// PARAMETERS
// - CODE_W      11  PI code width; the code wraps modulo 2**CODE_W.
// - CNT_W        6  signed vote-counter width; the counter saturates.
// - ACQ_THRESH   4  |vote count| that triggers a step in ACQUIRE.
// - TRK_THRESH  16  |vote count| that triggers a step in TRACK.
// - ACQ_STEP     8  code increment per step in ACQUIRE.
// - TRK_STEP     1  code increment per step in TRACK.
// - SETTLE       4  minimum clk cycles between code updates (PI settling time).
// - LOCK_REV     8  direction reversals needed to leave ACQUIRE.
// - UNLOCK_RUN  16  consecutive same-direction steps in TRACK that declare loss of lock.
// PORTS
// - clk        in   1       single clock, rising edge.
// - rst_n      in   1       asynchronous, active-low reset.
// - vote_vld   in   1       the vote_up/vote_dn pair is valid this cycle.
// - vote_up    in   1       data early: advance phase (code +).
// - vote_dn    in   1       data late: retard phase (code -).
// - freeze     in   1       hold code and counters.
// - load       in   1       one-cycle strobe: force pi_code to load_code.
// - load_code  in   CODE_W  value applied on load.
// - pi_code    out  CODE_W  registered code driven to the PI.
// - code_upd   out  1       one-cycle pulse in the cycle after pi_code changes.
// - locked     out  1       high while in TRACK.
// - state_o    out  2       current state, for debug.
// BEHAVIOUR
// - Reset (async): pi_code=0, code_upd=0, locked=0, state=ACQ, vote_cnt=0, settle_cnt=0, rev_cnt=0, run_cnt=0, last_dir=UP.
// - Votes, counted only when vote_vld=1 and state!=HOLD:
//   - up&~dn: vote_cnt+1; dn&~up: vote_cnt-1; both or neither: no change.
//   - vote_cnt saturates at +/-(2**(CNT_W-1)-1).
// - Step request: vote_cnt>=THR gives UP; vote_cnt<=-THR gives DN. THR = ACQ_THRESH in ACQ, TRK_THRESH in TRACK.
// - Step apply, when a request is present and settle_cnt==0, at the next edge:
//   - pi_code <= (pi_code +/- STEP) mod 2**CODE_W. Wraps 2047->0 and 0->2047 with no special case; octant carry is natural.
//   - vote_cnt <= 0; settle_cnt <= SETTLE-1; code_upd <= 1 for 1 cycle.
//   - Any vote arriving in the apply cycle is discarded.
// - Latency: a vote that makes the threshold at edge n (settle idle) gives the new pi_code at edge n+1.
// - While settle_cnt!=0: settle_cnt decrements each cycle. Votes still integrate (saturating). A pending request is applied, as one step only, on the first cycle settle_cnt==0.
// - Direction tracking per applied step:
//   - dir!=last_dir: rev_cnt++ (saturating), run_cnt=1.
//   - Else: run_cnt++ (saturating).
//   - last_dir <= dir.
// - State machine (enum ACQ, TRACK, HOLD):
//   - ACQ -> TRACK when rev_cnt reaches LOCK_REV. Sets locked=1, clears rev_cnt and vote_cnt.
//   - TRACK -> ACQ when run_cnt reaches UNLOCK_RUN. Clears locked, rev_cnt and vote_cnt.
//   - any -> HOLD while freeze=1. All counters and pi_code are held; settle_cnt keeps counting down.
//   - HOLD -> the saved prior state (ACQ/TRACK) on freeze=0. locked is unchanged by HOLD.
// - Priority: rst_n > load > freeze > step.
// - load:
//   - pi_code <= load_code; code_upd <= 1.
//   - vote_cnt, rev_cnt and run_cnt cleared; settle_cnt <= SETTLE-1.
//   - state <= ACQ, locked <= 0 (HOLD if freeze is also high, with saved state ACQ).
// - Threshold compare uses the registered vote_cnt. Reaching threshold exactly counts as a request.
// STRUCTURE
// - pi_ctrl_pkg:
//   - typedef enum logic[1:0] {ACQ=0, TRACK=1, HOLD=2} pi_state_t;
//   - typedef enum logic {DIR_UP, DIR_DN} pi_dir_t;
//   - localparam PI_CODE_W=11.
// - Sub-module vote_integrator: saturating signed up/down counter with clear and threshold compare, outputs req_up/req_dn. The top holds the FSM, settle timer, step adder and lock logic.
// TESTING
// - Reset, then 4 consecutive vote_up: pi_code 0->8 one cycle after the 4th vote; code_upd high 1 cycle.
// - pi_code=2044 in ACQ, 4 up votes: pi_code=4 (wrap). In TRACK at 2047, 16 up votes: pi_code=0.
// - Votes every cycle with SETTLE=4: successive updates are spaced >=4 cycles; a held-off request produces a single step.
// - Alternate runs of 4 up / 4 dn votes: after 8 reversals, locked=1 and step=1. Then 16x16 up votes: locked=0, state=ACQ.
// - freeze during a vote burst: pi_code and vote_cnt constant, state_o=HOLD. On release, returns to TRACK if it was locked.
// - load=1 with load_code=0x3A5 together with freeze and a threshold-crossing vote: pi_code=0x3A5, no step applied, state=HOLD. rst_n low mid-settle clears all outputs immediately.

Source files
------------

// File: rtl/pi_code_ctrl_pkg.sv
// Shared types and constants for the phase-interpolator code controller.
//   pi_state_t : loop state (coarse acquire, fine track, frozen)
//   pi_dir_t   : direction of an applied code step
package pi_ctrl_pkg;

  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } pi_state_t;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } pi_dir_t;

  localparam int PI_CODE_W = 11;

endpackage

// File: rtl/pi_code_ctrl_if.sv
// Bus between the CDR vote source / PI and the code controller.
//   master : drives votes, freeze, load/load_code; observes code and status
//   slave  : the controller side
interface pi_code_ctrl_if
  import pi_ctrl_pkg::*;
#(
  parameter int CODE_W = PI_CODE_W
);
  logic              vote_vld;
  logic              vote_up;
  logic              vote_dn;
  logic              freeze;
  logic              load;
  logic [CODE_W-1:0] load_code;
  logic [CODE_W-1:0] pi_code;
  logic              code_upd;
  logic              locked;
  logic [1:0]        state_o;

  modport master (
    output vote_vld, vote_up, vote_dn, freeze, load, load_code,
    input  pi_code, code_upd, locked, state_o
  );

  modport slave (
    input  vote_vld, vote_up, vote_dn, freeze, load, load_code,
    output pi_code, code_upd, locked, state_o
  );
endinterface

// File: rtl/pi_code_ctrl_vote_integrator.sv
// Saturating signed early/late vote counter with threshold compare.
//   en     : count this cycle's vote (up^dn only)
//   clr    : zero the counter (wins over en)
//   thr    : positive threshold magnitude
//   req_up : count >= +thr ; req_dn : count <= -thr
module vote_integrator #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             dn,
  input  logic             clr,
  input  logic [CNT_W-1:0] thr,
  output logic             req_up,
  output logic             req_dn
);
  localparam logic signed [CNT_W-1:0] MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] MIN = -MAX;
  localparam logic signed [CNT_W-1:0] ONE = 1;

  logic signed [CNT_W-1:0] cnt;
  logic signed [CNT_W-1:0] thr_s;

  assign thr_s  = signed'(thr);
  assign req_up = (cnt >= thr_s);
  assign req_dn = (cnt <= -thr_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (up ^ dn)) begin
      if (up && cnt != MAX)      cnt <= cnt + ONE;
      else if (dn && cnt != MIN) cnt <= cnt - ONE;
    end
  end
endmodule

// File: rtl/pi_code_ctrl.sv
// Phase-interpolator code sequencer for the RX CDR.
// Integrates bang-bang votes, steps pi_code (coarse in ACQ, fine in TRACK),
// enforces a PI settling gap between updates, and tracks lock via direction
// reversals (gain lock) and same-direction runs (lose lock).
//   clk, rst_n : clock, async active-low reset
//   bus.slave  : votes, freeze, load/load_code in; pi_code, code_upd,
//                locked, state_o out (all outputs registered)
module pi_code_ctrl
  import pi_ctrl_pkg::*;
#(
  parameter int CODE_W     = PI_CODE_W,
  parameter int CNT_W      = 6,
  parameter int ACQ_THRESH = 4,
  parameter int TRK_THRESH = 16,
  parameter int ACQ_STEP   = 8,
  parameter int TRK_STEP   = 1,
  parameter int SETTLE     = 4,
  parameter int LOCK_REV   = 8,
  parameter int UNLOCK_RUN = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  pi_code_ctrl_if.slave  bus
);
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int REV_W = $clog2(LOCK_REV + 1);
  localparam int RUN_W = $clog2(UNLOCK_RUN + 1);

  localparam logic [SET_W-1:0]  SETTLE_LD = SET_W'(SETTLE - 1);
  localparam logic [REV_W-1:0]  REV_LIM   = REV_W'(LOCK_REV);
  localparam logic [RUN_W-1:0]  RUN_LIM   = RUN_W'(UNLOCK_RUN);
  localparam logic [CNT_W-1:0]  ACQ_THR   = CNT_W'(ACQ_THRESH);
  localparam logic [CNT_W-1:0]  TRK_THR   = CNT_W'(TRK_THRESH);
  localparam logic [CODE_W-1:0] ACQ_INC   = CODE_W'(ACQ_STEP);
  localparam logic [CODE_W-1:0] TRK_INC   = CODE_W'(TRK_STEP);

  pi_state_t         state, saved_state;
  pi_dir_t           last_dir, step_dir;
  logic [CODE_W-1:0] pi_code, code_next, step_amt;
  logic [SET_W-1:0]  settle_cnt;
  logic [REV_W-1:0]  rev_cnt, rev_next;
  logic [RUN_W-1:0]  run_cnt, run_next;
  logic              code_upd, locked;
  logic              req_up, req_dn, step_go, int_en, int_clr;

  // Votes are ignored while frozen, including the first freeze cycle and the
  // cycle that leaves HOLD.
  assign int_en  = bus.vote_vld && !bus.freeze && (state != HOLD);
  assign int_clr = bus.load || step_go;

  vote_integrator #(.CNT_W(CNT_W)) u_vote (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (int_en),
    .up     (bus.vote_up),
    .dn     (bus.vote_dn),
    .clr    (int_clr),
    .thr    ((state == TRACK) ? TRK_THR : ACQ_THR),
    .req_up (req_up),
    .req_dn (req_dn)
  );

  always_comb begin
    step_dir  = req_up ? DIR_UP : DIR_DN;
    step_go   = (req_up || req_dn) && (settle_cnt == '0) && !bus.load
                && !bus.freeze && (state != HOLD);
    step_amt  = (state == TRACK) ? TRK_INC : ACQ_INC;
    code_next = (step_dir == DIR_UP) ? pi_code + step_amt : pi_code - step_amt;
    rev_next  = rev_cnt;
    run_next  = run_cnt;
    if (step_dir != last_dir) begin
      if (rev_cnt != '1) rev_next = rev_cnt + 1'b1;
      run_next = RUN_W'(1);
    end else if (run_cnt != '1) begin
      run_next = run_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACQ;
      saved_state <= ACQ;
      last_dir    <= DIR_UP;
      pi_code     <= '0;
      settle_cnt  <= '0;
      rev_cnt     <= '0;
      run_cnt     <= '0;
      code_upd    <= 1'b0;
      locked      <= 1'b0;
    end else begin
      code_upd <= 1'b0;
      // Settle timer runs in every state; branches below may reload it.
      if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;

      if (bus.load) begin
        pi_code     <= bus.load_code;
        code_upd    <= 1'b1;
        settle_cnt  <= SETTLE_LD;
        rev_cnt     <= '0;
        run_cnt     <= '0;
        locked      <= 1'b0;
        saved_state <= ACQ;
        state       <= bus.freeze ? HOLD : ACQ;
      end else if (bus.freeze) begin
        if (state != HOLD) saved_state <= state;
        state <= HOLD;
      end else if (state == HOLD) begin
        state <= saved_state;
      end else if (step_go) begin
        pi_code    <= code_next;
        code_upd   <= 1'b1;
        settle_cnt <= SETTLE_LD;
        last_dir   <= step_dir;
        rev_cnt    <= rev_next;
        run_cnt    <= run_next;
        if (state == ACQ && rev_next >= REV_LIM) begin
          state   <= TRACK;
          locked  <= 1'b1;
          rev_cnt <= '0;
        end else if (state == TRACK && run_next >= RUN_LIM) begin
          state   <= ACQ;
          locked  <= 1'b0;
          rev_cnt <= '0;
        end
      end
    end
  end

  assign bus.pi_code  = pi_code;
  assign bus.code_upd = code_upd;
  assign bus.locked   = locked;
  assign bus.state_o  = state;
endmodule
